// File: rtl/xbf_sample_framer.sv
// Serial-to-parallel sample framer feeding XBF_Top: packs NUM_CH interleaved samples into one indexed snapshot.
// Optional beat-gap timeout is enabled with `define XBF_FRAMER_TIMEOUT_EN.
module xbf_sample_framer #(
    parameter int DW     = 16,
    parameter int NUM_CH = 8,
    parameter int IDXW   = 12,
    parameter int TMO    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    input  logic                 s_first,
    output logic                 s_ready,
    output logic [NUM_CH*DW-1:0] m_data,
    output logic [IDXW-1:0]      m_idx,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_sync,
    output logic [7:0]           err_cnt,
    output logic [1:0]           dbg_state
);

    // Handshakes: a beat moves when s_valid & s_ready at a rising edge, a snapshot
    // moves when m_valid & m_ready; a raised m_valid holds m_data/m_idx until it moves.

    localparam int CW = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [DW-1:0]        fill_buf [NUM_CH];
    logic [IDXW-1:0]      idx_cnt;
    logic [NUM_CH*DW-1:0] fill_word;
    logic [NUM_CH*DW-1:0] done_word;
    logic                 beat;
    logic                 xfer;
    logic                 out_free;
    logic                 first_err;
    logic                 timeout;

    assign beat      = s_valid & s_ready;
    assign xfer      = m_valid & m_ready;
    assign out_free  = ~m_valid | m_ready;
    assign first_err = (state == FILL) & beat & s_first & (count != '0);
    assign dbg_state = state;

    // done_word is the snapshot as it stands once the current beat lands in the last lane.
    always_comb begin
        fill_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fill_word[k*DW +: DW] = fill_buf[k];
        end
        done_word = fill_word;
        done_word[(NUM_CH-1)*DW +: DW] = s_data;
    end

`ifdef XBF_FRAMER_TIMEOUT_EN
    localparam int GW = $clog2(TMO + 1);

    logic [GW-1:0] gap;

    // Fires on the TMO-th consecutive idle cycle of a partial snapshot.
    assign timeout = (state == FILL) && (count != '0) && !beat && (gap == GW'(TMO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if ((state != FILL) || (count == '0) || beat || timeout) begin
            gap <= '0;
        end else begin
            gap <= gap + GW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            count    <= '0;
            idx_cnt  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_idx    <= '0;
            s_ready  <= 1'b0;
            err_sync <= 1'b0;
            err_cnt  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                fill_buf[k] <= '0;
            end
        end else begin
            err_sync <= 1'b0;
            s_ready  <= 1'b1;
            if (xfer) begin
                m_valid <= 1'b0;
            end
            if (first_err || timeout) begin
                err_sync <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end

            case (state)
                SYNC: begin
                    if (beat && s_first) begin
                        fill_buf[0] <= s_data;
                        count       <= CW'(1);
                        state       <= FILL;
                    end
                end

                FILL: begin
                    if (timeout) begin
                        count <= '0;
                        state <= SYNC;
                    end else if (beat) begin
                        if (first_err) begin
                            // Misplaced channel 0 restarts the snapshot; no index is spent.
                            fill_buf[0] <= s_data;
                            count       <= CW'(1);
                        end else if (count == LAST) begin
                            count <= '0;
                            if (out_free) begin
                                m_data  <= done_word;
                                m_idx   <= idx_cnt;
                                idx_cnt <= idx_cnt + IDXW'(1);
                                m_valid <= 1'b1;
                            end else begin
                                fill_buf[LAST] <= s_data;
                                state          <= FULL;
                                s_ready        <= 1'b0;
                            end
                        end else begin
                            fill_buf[count] <= s_data;
                            count           <= count + CW'(1);
                        end
                    end
                end

                FULL: begin
                    if (xfer) begin
                        m_data  <= fill_word;
                        m_idx   <= idx_cnt;
                        idx_cnt <= idx_cnt + IDXW'(1);
                        m_valid <= 1'b1;
                        count   <= '0;
                        state   <= FILL;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end

                default: begin
                    count <= '0;
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbf_sample_framer.sv
// Directed bench for xbf_sample_framer (NUM_CH=8, IDXW=2 so index wrap is reachable).
// The timeout step runs only when XBF_FRAMER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_xbf_sample_framer;

    localparam int DW     = 16;
    localparam int NUM_CH = 8;
    localparam int IDXW   = 2;
    localparam int TMO    = 64;
    localparam int W      = IDXW + NUM_CH*DW;

    logic                 clk;
    logic                 rst;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_first;
    logic                 s_ready;
    logic [NUM_CH*DW-1:0] m_data;
    logic [IDXW-1:0]      m_idx;
    logic                 m_valid;
    logic                 m_ready;
    logic                 err_sync;
    logic [7:0]           err_cnt;
    logic [1:0]           dbg_state;

    int checks      = 0;
    int failures    = 0;
    int stalls      = 0;
    int err_pulses  = 0;
    int hs_count    = 0;
    int cyc         = 0;
    int hs_log[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held_word;
    logic         held = 1'b0;

    xbf_sample_framer #(
        .DW(DW), .NUM_CH(NUM_CH), .IDXW(IDXW), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_first(s_first), .s_ready(s_ready),
        .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid), .m_ready(m_ready),
        .err_sync(err_sync), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] snap(input logic [IDXW-1:0] idx, input logic [DW-1:0] base);
        logic [NUM_CH*DW-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_CH; k++) d[k*DW +: DW] = base + DW'(k);
        return {idx, d};
    endfunction

    // drivers
    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        stalls = 0; err_pulses = 0; hs_count = 0; hs_log.delete();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic first);
        logic acc;
        int   n;
        s_data = d; s_first = first; s_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_accepted", W'(acc), W'(1));
    endtask

    task automatic send_snap(input logic [DW-1:0] base);
        for (int k = 0; k < NUM_CH; k++) send(base + DW'(k), k == 0);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0; s_first = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard: every output handshake must match the head of exp_q
    always @(negedge clk) begin
        if (!rst) begin
            if (err_sync) err_pulses++;
            if (held) begin
                chk("hold_stable", {m_idx, m_data}, held_word);
                chk("hold_valid", W'(m_valid), W'(1));
            end
            if (m_valid && m_ready) begin
                hs_count++;
                hs_log.push_back(cyc);
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL snap_unexpected observed=%0h expected=none", {m_idx, m_data});
                end
                if (exp_q.size() != 0) chk("snapshot", {m_idx, m_data}, exp_q.pop_front());
            end
            held      = m_valid && !m_ready;
            held_word = {m_idx, m_data};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        m_ready = 1'b1;
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset values
        chk("rst_m_valid", W'(m_valid), W'(0));
        chk("rst_s_ready", W'(s_ready), W'(0));
        chk("rst_m_data", W'(m_data), W'(0));
        chk("rst_m_idx", W'(m_idx), W'(0));
        chk("rst_err_cnt", W'(err_cnt), W'(0));
        chk("rst_err_sync", W'(err_sync), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", W'(s_ready), W'(1));

        // 1: two aligned snapshots, m_ready high
        exp_q.push_back(snap(2'd0, 16'h0100));
        exp_q.push_back(snap(2'd1, 16'h0108));
        for (int n = 0; n < 7; n++) send(16'h0100 + 16'(n), n == 0);
        chk("t1_no_valid_early", W'(m_valid), W'(0));
        send(16'h0107, 1'b0);
        chk("t1_latency0", W'(m_valid), W'(1));
        for (int n = 8; n < 15; n++) send(16'h0100 + 16'(n), n == 8);
        chk("t1_valid_dropped", W'(m_valid), W'(0));
        send(16'h010F, 1'b0);
        chk("t1_latency1", W'(m_valid), W'(1));
        idle(3);
        chk("t1_no_stall", W'(stalls), W'(0));
        chk("t1_count", W'(hs_count), W'(2));
        chk("t1_queue_empty", W'(exp_q.size()), W'(0));

        // 2: unaligned beats dropped in SYNC
        do_reset();
        exp_q.push_back(snap(2'd0, 16'h0200));
        for (int n = 0; n < 3; n++) send(16'hAA00 + 16'(n), 1'b0);
        send_snap(16'h0200);
        idle(3);
        chk("t2_count", W'(hs_count), W'(1));
        chk("t2_err_cnt", W'(err_cnt), W'(0));
        chk("t2_queue_empty", W'(exp_q.size()), W'(0));

        // 3: s_first at count 5 restarts the fill
        do_reset();
        exp_q.push_back(snap(2'd0, 16'h0400));
        for (int n = 0; n < 5; n++) send(16'h0300 + 16'(n), n == 0);
        send(16'h0400, 1'b1);
        chk("t3_err_pulse", W'(err_sync), W'(1));
        chk("t3_err_cnt", W'(err_cnt), W'(1));
        for (int n = 1; n < NUM_CH; n++) send(16'h0400 + 16'(n), 1'b0);
        idle(3);
        chk("t3_err_pulses", W'(err_pulses), W'(1));
        chk("t3_count", W'(hs_count), W'(1));
        chk("t3_queue_empty", W'(exp_q.size()), W'(0));

        // 4: backpressure, FULL, then back-to-back drain
        do_reset();
        m_ready = 1'b0;
        exp_q.push_back(snap(2'd0, 16'h0500));
        exp_q.push_back(snap(2'd1, 16'h0600));
        send_snap(16'h0500);
        send_snap(16'h0600);
        chk("t4_s_ready_drop", W'(s_ready), W'(0));
        idle(4);
        chk("t4_full_state", W'(dbg_state), W'(2));
        chk("t4_held_data", {m_idx, m_data}, snap(2'd0, 16'h0500));
        chk("t4_no_xfer", W'(hs_count), W'(0));
        m_ready = 1'b1;
        idle(4);
        chk("t4_count", W'(hs_count), W'(2));
        if (hs_log.size() == 2) chk("t4_consecutive", W'(hs_log[1] - hs_log[0]), W'(1));
        chk("t4_s_ready_back", W'(s_ready), W'(1));
        chk("t4_valid_clear", W'(m_valid), W'(0));
        chk("t4_queue_empty", W'(exp_q.size()), W'(0));

        // 5: index wraps with IDXW=2
        do_reset();
        for (int s = 0; s < 5; s++) exp_q.push_back(snap(2'(s), 16'h0700 + 16'(8*s)));
        for (int s = 0; s < 5; s++) send_snap(16'h0700 + 16'(8*s));
        idle(3);
        chk("t5_no_stall", W'(stalls), W'(0));
        chk("t5_count", W'(hs_count), W'(5));
        chk("t5_last_idx", W'(m_idx), W'(0));
        chk("t5_queue_empty", W'(exp_q.size()), W'(0));

        // 6: reset mid-fill discards the partial snapshot
        do_reset();
        for (int n = 0; n < 4; n++) send(16'h0800 + 16'(n), n == 0);
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_m_valid", W'(m_valid), W'(0));
        chk("t6_rst_s_ready", W'(s_ready), W'(0));
        do_reset();
        exp_q.push_back(snap(2'd0, 16'h0900));
        send_snap(16'h0900);
        idle(3);
        chk("t6_count", W'(hs_count), W'(1));
        chk("t6_queue_empty", W'(exp_q.size()), W'(0));

`ifdef XBF_FRAMER_TIMEOUT_EN
        // 7: 64 idle cycles at count 3 abort the fill
        do_reset();
        for (int n = 0; n < 3; n++) send(16'h0A00 + 16'(n), n == 0);
        idle(TMO - 1);
        chk("t7_no_early_err", W'(err_pulses), W'(0));
        idle(2);
        chk("t7_err_pulses", W'(err_pulses), W'(1));
        chk("t7_err_cnt", W'(err_cnt), W'(1));
        chk("t7_sync_state", W'(dbg_state), W'(0));
        chk("t7_no_snap", W'(hs_count), W'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
